// File: rtl/mem_responder.sv
// mem_responder: word-organised memory with one registered read port and one
// byte-lane write port. Reads are formatted (sign/zero extension) by funct3 and
// appear one cycle after the address is sampled. Writes update only the lanes
// selected by funct3 and the low address bits.
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to treat misaligned half/word
// accesses as errors (write suppressed, read returns zero, sticky misalign_err).
// Without it, half accesses ignore address[0] and word accesses ignore
// address[1:0].
module mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_valid,
  input  logic        write_mem,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [2:0]  funct3,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Storage has no reset so contents persist across rst; it relies on the
  // zero power-up state of the memory.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q;

  logic [AW-1:0] rd_idx, wr_idx;
  logic [31:0]   rd_word;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lanes;
  logic [31:0]   wr_mask;

  // Upper address bits deliberately take no part in indexing (addresses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_address[31:AW+2], write_address[31:AW+2]};

  assign rd_idx  = read_address[AW+1:2];
  assign wr_idx  = write_address[AW+1:2];
  assign rd_word = mem_q[rd_idx];

  // Extract and extend the addressed byte/half according to funct3.
  function automatic logic [31:0] fmt_read(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  // Half accesses need address[0]=0, word accesses need address[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] lo);
    if (f3[1:0] == 2'b01) return lo[0];
    if (f3 == 3'b010)     return (lo != 2'b00);
    return 1'b0;
  endfunction

  logic rd_mis, wr_mis;
  logic misalign_err_q, misalign_err_d;
  assign rd_mis = is_misaligned(funct3, read_address[1:0]);
  assign wr_mis = write_mem & is_misaligned(funct3, write_address[1:0]);
`endif

  // Lane enables and lane-replicated write data for the current write request.
  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = 32'h0;
    case (funct3)
      3'b000: begin
        wr_be    = 4'b0001 << write_address[1:0];
        wr_lanes = {4{write_data[7:0]}};
      end
      3'b001: begin
        wr_be    = write_address[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{write_data[15:0]}};
      end
      3'b010: begin
        wr_be    = 4'b1111;
        wr_lanes = write_data;
      end
      default: begin
        wr_be    = 4'b0000;
        wr_lanes = 32'h0;
      end
    endcase
    if (!write_mem) wr_be = 4'b0000;
`ifdef MEM_MISALIGN_CHECK_EN
    if (wr_mis) wr_be = 4'b0000;
`endif
    wr_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
  end

  // Next read result, formatted from the pre-write array contents.
  always_comb begin
    read_data_d = fmt_read(rd_word, funct3, read_address[1:0]);
`ifdef MEM_MISALIGN_CHECK_EN
    if (rd_mis) read_data_d = 32'h0;
`endif
  end

  // Array update; a write is either fully applied or fully dropped when rst is high.
  always_ff @(posedge clk) begin
    if (!rst && (wr_be != 4'b0000)) begin
      mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wr_lanes & wr_mask);
    end
  end

  // Registered read port and valid flag, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= 1'b1;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_err_d = misalign_err_q | rd_mis | wr_mis;

  // Sticky misalignment flag, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_err_q <= 1'b0;
    else     misalign_err_q <= misalign_err_d;
  end

  assign misalign_err = misalign_err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have one parameter line: DEPTH_WORDS, 1024, number of 32-bit words held (power of two, 16..65536).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port read_address, input, 32, byte address of the instruction/data read.
REQ-005 The block SHALL have port read_data, output, 32, registered read result.
REQ-006 The block SHALL have port read_valid, output, 1, read_data holds a result for a sampled address.
REQ-007 The block SHALL have port write_mem, input, 1, write enable.
REQ-008 The block SHALL have port write_address, input, 32, byte address of the write.
REQ-009 The block SHALL have port write_data, input, 32, write payload, LSB-aligned.
REQ-010 The block SHALL have port funct3, input, 3, access size/sign shared by read and write.
REQ-011 The block SHALL have port misalign_err, output, 1, sticky misaligned-access flag.

Function
REQ-012 The word index SHALL be address[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so out-of-range addresses wrap.
REQ-013 Every cycle, read_data SHALL capture the funct3-formatted word at read_address, giving one-cycle latency.
REQ-014 Read formatting: 000 sign-extended byte; 001 sign-extended half; 010 word; 100 zero-extended byte; 101 zero-extended half.
REQ-015 The byte lane SHALL be address[1:0] and the half lane SHALL be address[1].
REQ-016 Reads with funct3 011, 110 or 111 SHALL return the full word.
REQ-017 When write_mem=1, the block SHALL write only the lanes selected by funct3 and write_address at the clock edge: 000 one byte from write_data[7:0], 001 two bytes from [15:0], 010 four bytes.
REQ-018 Writes with funct3 outside {000,001,010} SHALL be suppressed.
REQ-019 A same-cycle write and read of the same word SHALL return the old (pre-write) data; the new data SHALL be visible on the next cycle's read.
REQ-020 read_valid SHALL be 0 in reset and rise on the first rising edge after rst deasserts.
REQ-021 read_valid SHALL then stay 1 until the next reset.
REQ-022 The storage array SHALL NOT be reset; it SHALL power up as all zeros.

Reset
REQ-023 While rst=1, read_data SHALL be 32'h0, read_valid 0 and misalign_err 0, regardless of clk.
REQ-024 While rst=1, writes SHALL be ignored.
REQ-025 Reset asserted mid-write SHALL leave the array either fully unwritten or fully written for that cycle, never partially written.
REQ-026 Array contents SHALL survive reset.

Configuration
REQ-027 The macro MEM_MISALIGN_CHECK_EN SHALL select misaligned-access handling.
REQ-028 With MEM_MISALIGN_CHECK_EN defined: a half access with address[0]=1, or a word access with address[1:0]!=0, SHALL suppress the write, return 32'h0 on a read, and set misalign_err until reset.
REQ-029 Without MEM_MISALIGN_CHECK_EN: half accesses SHALL ignore address[0], word accesses SHALL ignore address[1:0], and misalign_err SHALL be constant 0.

Verification
REQ-030 The bench SHALL cover: rst pulse, release, read_address=0 with memory zero -> read_valid=1 one cycle after release, read_data=32'h0.
REQ-031 The bench SHALL cover: SW 32'h8000_00F3 to 0x10, then LB/LBU/LH/LHU/LW at 0x10 -> FFFF_FFF3, 0000_00F3, 0000_00F3, 0000_00F3, 8000_00F3.
REQ-032 The bench SHALL cover: SB 8'hAB to 0x13 over word 0x11223344 -> LW 0x10 returns AB223344, with the other lanes unchanged.
REQ-033 The bench SHALL cover: same-cycle SW 0xDEADBEEF and LW, both at 0x20 holding 0 -> first read 0, next-cycle read DEADBEEF.
REQ-034 The bench SHALL cover: write to 4*DEPTH_WORDS+4 -> readable at 0x4 (wrap).
REQ-035 The bench SHALL cover: SW at 0x22 -> with MEM_MISALIGN_CHECK_EN, memory unchanged and misalign_err=1 until rst; without it, the word at 0x20 is written and misalign_err=0.
